ofdm_rx_byte_packer: RTL and testbench

Downstream stage of the OFDM RX path. Consumes the demodulated 2-bit QPSK stream (`rx_rcv_data` / `rx_rcv_data_valid` / `rx_rcv_data_start`) and packs it into bytes. It tracks symbol boundaries, detects truncated symbols, and buffers bytes in a small FIFO behind a valid/ready interface for the MAC-side consumer.

---
 rtl/ofdm_rx_pkg.sv | 22 ++
 rtl/ofdm_rx_byte_fifo.sv | 73 +++++++
 rtl/ofdm_rx_byte_packer.sv | 218 +++++++++++++++++++++
 tb/tb_ofdm_rx_byte_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_rx_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_rx_pkg
// Types shared by the OFDM RX byte packer and its output FIFO.
//   dibit_t        : one demodulated QPSK dibit, first bit in bit 0
//   fifo_word_t    : one FIFO entry, start-of-symbol flag plus data byte
//   packer_state_t : packer FSM states
// ---------------------------------------------------------------------------
package ofdm_rx_pkg;

    typedef logic [1:0] dibit_t;

    typedef struct packed {
        logic       sof;
        logic [7:0] data;
    } fifo_word_t;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } packer_state_t;

endpackage : ofdm_rx_pkg

// File: rtl/ofdm_rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// ofdm_rx_byte_fifo
// Synchronous first-word-fall-through FIFO of fifo_word_t entries.
// The head entry is visible on head_word whenever empty is low.
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise the pushed word is ignored (the caller flags the drop).
//
// Ports
//   clk       in   clock
//   clear     in   synchronous clear of pointers and occupancy
//   push      in   write push_word this cycle
//   push_word in   word to write
//   pop       in   remove head this cycle (ignored while empty)
//   head_word out  current head entry
//   full      out  occupancy == depth_g
//   empty     out  occupancy == 0
// ---------------------------------------------------------------------------
module ofdm_rx_byte_fifo
    import ofdm_rx_pkg::*;
#(
    parameter int depth_g = 16
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       push,
    input  fifo_word_t push_word,
    input  logic       pop,
    output fifo_word_t head_word,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(depth_g);

    fifo_word_t      mem [depth_g];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            wr_en;
    logic            rd_en;

    assign full  = (count_reg == (AW+1)'(depth_g));
    assign empty = (count_reg == '0);

    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    assign head_word = mem[rd_ptr_reg];

endmodule : ofdm_rx_byte_fifo

// File: rtl/ofdm_rx_byte_packer.sv
// ---------------------------------------------------------------------------
// ofdm_rx_byte_packer
// Packs the demodulated QPSK dibit stream into bytes, tracks symbol
// boundaries, flags truncated symbols and buffers bytes in a FWFT FIFO
// behind a valid/ready interface.
//
// Optional build macro: OFDM_RX_PACKER_STATS_EN adds symbol_count and
// error_count (16-bit, saturating).
//
// Ports
//   sys_clk           in   system clock
//   sys_rstn          in   synchronous active-low reset
//   sys_init          in   synchronous clear, same effect as reset
//   rx_rcv_data       in   dibit, first bit in bit 0
//   rx_rcv_data_valid in   dibit strobe
//   rx_rcv_data_start in   first dibit of a symbol (qualified by valid)
//   byte_data         out  FIFO head byte
//   byte_sof          out  head byte is byte 0 of a symbol
//   byte_valid        out  FIFO not empty
//   byte_ready        in   consumer pops head when valid && ready
//   symbol_count      out  completed symbols (stats build only)
//   error_count       out  short symbols + dropped bytes (stats build only)
//   overflow          out  sticky, a byte was dropped on a full FIFO
//   short_symbol      out  one-cycle pulse, start arrived mid-symbol
// ---------------------------------------------------------------------------
module ofdm_rx_byte_packer
    import ofdm_rx_pkg::*;
#(
    parameter int dibits_per_symbol_g = 128,
    parameter int fifo_depth_g        = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rstn,
    input  logic        sys_init,
    input  logic [1:0]  rx_rcv_data,
    input  logic        rx_rcv_data_valid,
    input  logic        rx_rcv_data_start,
    output logic [7:0]  byte_data,
    output logic        byte_sof,
    output logic        byte_valid,
    input  logic        byte_ready,
`ifdef OFDM_RX_PACKER_STATS_EN
    output logic [15:0] symbol_count,
    output logic [15:0] error_count,
`endif
    output logic        overflow,
    output logic        short_symbol
);

    localparam int CNT_W         = $clog2(dibits_per_symbol_g) + 1;
    localparam int BYTES_PER_SYM = dibits_per_symbol_g / 4;
    localparam int BCNT_W        = (BYTES_PER_SYM > 1) ? $clog2(BYTES_PER_SYM) : 1;
    localparam logic [CNT_W-1:0]  LAST_DIBIT = CNT_W'(dibits_per_symbol_g - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(BYTES_PER_SYM - 1);

    packer_state_t     state_reg, state_next;
    logic [CNT_W-1:0]  dcnt_reg, dcnt_next;
    logic [BCNT_W-1:0] bcnt_reg, bcnt_next;
    logic [5:0]        pack_reg, pack_next;     // dibits 0..2 of the byte in progress
    logic              push_reg, push_next;
    fifo_word_t        push_word_reg, push_word_next;
    logic              short_reg, short_next;
    logic              overflow_reg;

    logic              clear;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_drop;
    fifo_word_t        head_word;
    dibit_t            din;

    assign clear = !sys_rstn || sys_init;
    assign din   = rx_rcv_data;

    // ---------------------------------------------------------------------
    // Packer FSM: next-state and datapath
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        dcnt_next      = dcnt_reg;
        bcnt_next      = bcnt_reg;
        pack_next      = pack_reg;
        push_next      = 1'b0;
        push_word_next = push_word_reg;
        short_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (rx_rcv_data_valid && rx_rcv_data_start) begin
                    state_next = COLLECT;
                    dcnt_next  = CNT_W'(1);
                    bcnt_next  = '0;
                    pack_next  = {4'b0000, din};
                end
            end

            COLLECT: begin
                if (rx_rcv_data_valid) begin
                    if (rx_rcv_data_start) begin
                        // Truncated symbol: drop the partial byte and restart
                        // with this dibit as dibit 0 of a new symbol.
                        short_next = 1'b1;
                        dcnt_next  = CNT_W'(1);
                        bcnt_next  = '0;
                        pack_next  = {4'b0000, din};
                    end else begin
                        dcnt_next = dcnt_reg + CNT_W'(1);
                        case (dcnt_reg[1:0])
                            2'd0: pack_next[1:0] = din;
                            2'd1: pack_next[3:2] = din;
                            2'd2: pack_next[5:4] = din;
                            default: begin
                                // 4th dibit completes the byte straight from
                                // the input, so it never sits in pack_reg.
                                push_next           = 1'b1;
                                push_word_next.sof  = (bcnt_reg == '0);
                                push_word_next.data = {din, pack_reg};
                                bcnt_next = (bcnt_reg == LAST_BYTE) ? '0
                                                                    : bcnt_reg + BCNT_W'(1);
                            end
                        endcase
                        // N is a multiple of 4, so the last dibit always
                        // lands in the push branch above.
                        if (dcnt_reg == LAST_DIBIT) begin
                            state_next = IDLE;
                            dcnt_next  = '0;
                        end
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (clear) begin
            state_reg     <= IDLE;
            dcnt_reg      <= '0;
            bcnt_reg      <= '0;
            pack_reg      <= '0;
            push_reg      <= 1'b0;
            push_word_reg <= '0;
            short_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            dcnt_reg      <= dcnt_next;
            bcnt_reg      <= bcnt_next;
            pack_reg      <= pack_next;
            push_reg      <= push_next;
            push_word_reg <= push_word_next;
            short_reg     <= short_next;
            overflow_reg  <= overflow_reg | fifo_drop;
        end
    end

    // ---------------------------------------------------------------------
    // Output FIFO
    // ---------------------------------------------------------------------
    assign pop       = byte_ready && !fifo_empty;
    assign fifo_drop = push_reg && fifo_full && !pop;

    ofdm_rx_byte_fifo #(
        .depth_g (fifo_depth_g)
    ) u_fifo (
        .clk       (sys_clk),
        .clear     (clear),
        .push      (push_reg),
        .push_word (push_word_reg),
        .pop       (pop),
        .head_word (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Head is masked while empty so the outputs read 0 out of reset even
    // though the storage array itself is never cleared.
    assign byte_valid   = !fifo_empty;
    assign byte_data    = fifo_empty ? 8'h00 : head_word.data;
    assign byte_sof     = !fifo_empty && head_word.sof;
    assign overflow     = overflow_reg;
    assign short_symbol = short_reg;

`ifdef OFDM_RX_PACKER_STATS_EN
    // ---------------------------------------------------------------------
    // Statistics counters (saturating)
    // ---------------------------------------------------------------------
    logic [15:0] sym_cnt_reg;
    logic [15:0] err_cnt_reg;
    logic        sym_done;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    assign sym_done = (state_reg == COLLECT) && rx_rcv_data_valid &&
                      !rx_rcv_data_start && (dcnt_reg == LAST_DIBIT);
    // A short symbol and a dropped byte can land on the same edge.
    assign err_inc  = {1'b0, short_next} + {1'b0, fifo_drop};
    assign err_sum  = {1'b0, err_cnt_reg} + {15'b0, err_inc};

    always_ff @(posedge sys_clk) begin
        if (clear) begin
            sym_cnt_reg <= '0;
            err_cnt_reg <= '0;
        end else begin
            if (sym_done && (sym_cnt_reg != 16'hFFFF)) begin
                sym_cnt_reg <= sym_cnt_reg + 16'd1;
            end
            err_cnt_reg <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign symbol_count = sym_cnt_reg;
    assign error_count  = err_cnt_reg;
`endif

endmodule : ofdm_rx_byte_packer

// File: tb/tb_ofdm_rx_byte_packer.sv
// ---------------------------------------------------------------------------
// tb_ofdm_rx_byte_packer
// Self-checking bench for ofdm_rx_byte_packer (N = 8 dibits per symbol,
// 16-byte FIFO). A queue-based reference model is updated at every clock
// edge and all outputs are compared on the falling edge. Directed cases
// follow the documented scenarios, then a randomized run.
// ---------------------------------------------------------------------------
module tb_ofdm_rx_byte_packer;

    localparam int N     = 8;
    localparam int DEPTH = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rstn = 1'b0;
    logic       sys_init = 1'b0;
    logic [1:0] rx_rcv_data = 2'b00;
    logic       rx_rcv_data_valid = 1'b0;
    logic       rx_rcv_data_start = 1'b0;
    logic       byte_ready = 1'b0;
    logic [7:0] byte_data;
    logic       byte_sof;
    logic       byte_valid;
    logic       overflow;
    logic       short_symbol;
`ifdef OFDM_RX_PACKER_STATS_EN
    logic [15:0] symbol_count;
    logic [15:0] error_count;
`endif

    always #5 sys_clk = ~sys_clk;

    ofdm_rx_byte_packer #(
        .dibits_per_symbol_g (N),
        .fifo_depth_g        (DEPTH)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rstn          (sys_rstn),
        .sys_init          (sys_init),
        .rx_rcv_data       (rx_rcv_data),
        .rx_rcv_data_valid (rx_rcv_data_valid),
        .rx_rcv_data_start (rx_rcv_data_start),
        .byte_data         (byte_data),
        .byte_sof          (byte_sof),
        .byte_valid        (byte_valid),
        .byte_ready        (byte_ready),
`ifdef OFDM_RX_PACKER_STATS_EN
        .symbol_count      (symbol_count),
        .error_count       (error_count),
`endif
        .overflow          (overflow),
        .short_symbol      (short_symbol)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    logic [8:0] m_q[$];        // {sof, data} bytes held in the FIFO
    bit         m_pend_v;      // byte completed, enters FIFO on next edge
    logic [8:0] m_pend;
    bit         m_in_sym;
    int         m_nd;          // dibits received in current symbol
    logic [1:0] m_cur[$];      // dibits of the byte in progress
    int         m_bidx;        // byte index within symbol
    bit         m_ovf;
    bit         m_short;
    int         m_sym;
    int         m_err;

    logic [8:0] popped[$];     // bytes observed leaving the DUT
    int         short_seen;
    bit         rdy = 1'b0;
    logic [1:0] pat [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_pend_v = 1'b0;
        m_pend   = '0;
        m_in_sym = 1'b0;
        m_nd     = 0;
        m_cur.delete();
        m_bidx   = 0;
        m_ovf    = 1'b0;
        m_short  = 1'b0;
        m_sym    = 0;
        m_err    = 0;
    endtask

    task automatic model_edge(input bit v, input bit s, input logic [1:0] d,
                              input bit r, input bit init);
        if (init) begin
            model_clear();
            return;
        end
        if (r && m_q.size() > 0) void'(m_q.pop_front());
        if (m_pend_v) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_pend);
            else begin
                m_ovf = 1'b1;
                m_err++;
            end
        end
        m_pend_v = 1'b0;
        m_short  = 1'b0;
        if (v) begin
            if (s) begin
                if (m_in_sym) begin
                    m_short = 1'b1;
                    m_err++;
                end
                m_in_sym = 1'b1;
                m_nd     = 1;
                m_bidx   = 0;
                m_cur.delete();
                m_cur.push_back(d);
            end else if (m_in_sym) begin
                m_cur.push_back(d);
                m_nd++;
                if (m_cur.size() == 4) begin
                    m_pend   = {(m_bidx == 0), m_cur[3], m_cur[2], m_cur[1], m_cur[0]};
                    m_pend_v = 1'b1;
                    m_bidx++;
                    m_cur.delete();
                end
                if (m_nd == N) begin
                    m_in_sym = 1'b0;
                    m_sym++;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("valid", byte_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check_eq("data", byte_data, m_q[0][7:0]);
            check_eq("sof", byte_sof, m_q[0][8]);
        end
        check_eq("short", short_symbol, m_short);
        check_eq("ovf", overflow, m_ovf);
`ifdef OFDM_RX_PACKER_STATS_EN
        check_eq("sym_cnt", symbol_count, (m_sym > 65535) ? 65535 : m_sym);
        check_eq("err_cnt", error_count, (m_err > 65535) ? 65535 : m_err);
`endif
        if (short_symbol) short_seen++;
    endtask

    // One clock cycle: drive at the falling edge, model at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input bit v, input bit s, input logic [1:0] d, input bit init);
        rx_rcv_data_valid = v;
        rx_rcv_data_start = s;
        rx_rcv_data       = d;
        sys_init          = init;
        byte_ready        = rdy;
        #1;
        if (byte_valid && byte_ready && !init) begin
            popped.push_back({byte_sof, byte_data});
            $display("POP data=0x%02h sof=%0b", byte_data, byte_sof);
        end
        @(posedge sys_clk);
        model_edge(v, s, d, rdy, init);
        @(negedge sys_clk);
        compare_all();
    endtask

    task automatic send(input bit s, input logic [1:0] d);
        cycle(1'b1, s, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic send_sym();
        for (int i = 0; i < N; i++) send(i == 0, pat[i]);
    endtask

    task automatic do_init();
        cycle(1'b0, 1'b0, 2'd0, 1'b1);
    endtask

    initial begin
        model_clear();
        short_seen = 0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check_eq("rst_valid", byte_valid, 1'b0);
        check_eq("rst_data", byte_data, 8'h00);
        check_eq("rst_sof", byte_sof, 1'b0);
        check_eq("rst_ovf", overflow, 1'b0);
        check_eq("rst_short", short_symbol, 1'b0);
        sys_rstn = 1'b1;

        // Basic symbol
        rdy = 1'b1;
        popped.delete();
        send_sym();
        idle(4);
        check_eq("t1_cnt", popped.size(), 2);
        if (popped.size() == 2) begin
            check_eq("t1_b0", popped[0], 9'h139);
            check_eq("t1_b1", popped[1], 9'h0E4);
        end

        // Dibits without start are ignored
        popped.delete();
        send(1'b0, 2'd1); send(1'b0, 2'd2); send(1'b0, 2'd3);
        idle(3);
        check_eq("t2_cnt", popped.size(), 0);

        // Truncated symbol followed by a full one
        popped.delete();
        short_seen = 0;
        send(1'b1, 2'd1); send(1'b0, 2'd2); send(1'b0, 2'd3);
        send(1'b0, 2'd0); send(1'b0, 2'd1); send(1'b0, 2'd2);
        send(1'b1, 2'd0);
        for (int i = 0; i < 3; i++) send(1'b0, 2'd0);
        for (int i = 0; i < 4; i++) send(1'b0, 2'd1);
        idle(4);
        check_eq("t3_short", short_seen, 1);
        check_eq("t3_cnt", popped.size(), 3);
        if (popped.size() == 3) begin
            check_eq("t3_b0", popped[0], 9'h139);
            check_eq("t3_b1", popped[1], 9'h100);
            check_eq("t3_b2", popped[2], 9'h055);
        end

        // Overflow with consumer stalled, then drain
        rdy = 1'b0;
        repeat (9) send_sym();
        idle(3);
        check_eq("t4_ovf", overflow, 1'b1);
        check_eq("t4_valid", byte_valid, 1'b1);
        rdy = 1'b1;
        popped.delete();
        idle(24);
        check_eq("t4_cnt", popped.size(), 16);
        if (popped.size() == 16) begin
            check_eq("t4_b0", popped[0], 9'h139);
            check_eq("t4_b1", popped[1], 9'h0E4);
        end
        check_eq("t4_empty", byte_valid, 1'b0);

        // Init mid-symbol
        send(1'b1, 2'd1); send(1'b0, 2'd2);
        do_init();
        check_eq("t5_valid", byte_valid, 1'b0);
        check_eq("t5_ovf", overflow, 1'b0);
        check_eq("t5_short", short_symbol, 1'b0);
        popped.delete();
        send_sym();
        idle(4);
        check_eq("t5_cnt", popped.size(), 2);
        if (popped.size() == 2) check_eq("t5_b0", popped[0], 9'h139);

`ifdef OFDM_RX_PACKER_STATS_EN
        do_init();
        repeat (3) send_sym();
        send(1'b1, 2'd1); send(1'b0, 2'd2); send(1'b0, 2'd3);
        send(1'b1, 2'd0);
        idle(2);
        check_eq("t6_sym", symbol_count, 16'd3);
        check_eq("t6_err", error_count, 16'd1);
`endif

        // Randomized run against the model
        do_init();
        for (int i = 0; i < 3000; i++) begin
            rdy = ((i / 150) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                do_init();
            end else if ($urandom_range(0, 9) < 7) begin
                send($urandom_range(0, 11) == 0, 2'($urandom_range(0, 3)));
            end else begin
                idle(1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ofdm_rx_byte_packer
